cp0_regfile: RTL and testbench
==============================

CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 The ports SHALL be, in this order:
- clk  in  1  clock
- rst  in  1  async active-high reset
- exc_valid  in  1  WB-stage exception commit
- exc_code  in  5  ExcCode to record
- exc_bd  in  1  excepting instruction is in a delay slot
- exc_pc  in  32  PC of the excepting instruction
- badaddr_we  in  1  load BadVAddr on exception
- exc_badaddr  in  32  faulting address
- eret  in  1  WB-stage ERET commit
- mtc0_we  in  1  MTC0 commit
- mtc0_addr  in  5  destination CP0 register number
- mtc0_wdata  in  32  MTC0 data
- mfc0_addr  in  5  MFC0 source register number
- hw_int  in  6  external interrupt lines, level
- mfc0_rdata  out  32  combinational read data
- epc_out  out  32  current EPC
- status_exl  out  1  Status.EXL
- int_req  out  1  interrupt request to the WB control unit

Function
REQ-003 The block SHALL implement registers BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13) and EPC(14); any other mfc0_addr SHALL read 32'h0.
REQ-004 mfc0_rdata SHALL be combinational from current register state, with no bypass of a same-cycle write.
REQ-005 When more than one commit is asserted in a cycle, priority SHALL be exc_valid > eret > mtc0_we; a lower-priority commit in that cycle SHALL be ignored.
REQ-006 On exc_valid:
- Status.EXL(bit1) <= 1, Cause.ExcCode(bits6:2) <= exc_code.
- If EXL was 0: Cause.BD(bit31) <= exc_bd, and EPC <= exc_bd ? exc_pc-4 : exc_pc (32-bit modulo arithmetic).
- If EXL was already 1: EPC and BD are unchanged.
- BadVAddr <= exc_badaddr only if badaddr_we.
REQ-007 On eret, Status.EXL SHALL be cleared; no other field changes.
REQ-008 MTC0 write masks:
- Status: only IM(15:8), EXL(1), IE(0) are writable.
- Cause: only IP1:0 (bits9:8) are writable.
- EPC, Count and Compare: fully writable.
- BadVAddr and unimplemented numbers: the write is ignored.
REQ-009 Cause.IP[15:10] SHALL be registered from hw_int every cycle. IP7 (bit15) is hw_int[5] OR'd with the timer interrupt (TI, Cause bit30).
REQ-010 int_req SHALL be Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]), combinational from registered state.
REQ-011 epc_out SHALL equal EPC and status_exl SHALL equal Status.EXL, combinationally.

Reset
REQ-012 While rst is asserted:
- Status = 32'h0040_0000 (BEV=1).
- Cause, EPC, BadVAddr, Count and Compare = 0; the Count tick toggle and TI = 0.
- Outputs follow from these values: int_req=0, status_exl=0, epc_out=0.
REQ-013 Reset asserted mid-operation SHALL discard every commit sampled in that cycle.

Configuration
REQ-014 Macro CP0_TIMER_EN SHALL control the timer:
- Defined:
  - Count increments by 1 every second clock (toggle bit), wrapping 32'hFFFF_FFFF->0.
  - An MTC0 to Count in a cycle overrides the increment and clears the toggle.
  - When Count==Compare and Compare!=0, TI is set on the next edge.
  - An MTC0 to Compare clears TI in the same edge, and a write takes priority over a match.
- Undefined: Count and Compare read 0, writes to them are ignored, and TI stays 0.

Verification
REQ-015 The bench SHALL cover at least these directed scenarios:
- Exception, not in a delay slot: exc_valid=1, exc_code=5'd4, exc_bd=0, exc_pc=32'hBFC0_0100, badaddr_we=1, exc_badaddr=32'h0000_0003 -> next cycle EPC=32'hBFC0_0100, Cause[6:2]=4, BD=0, BadVAddr=32'h3, EXL=1.
- Exception in a delay slot with EXL=0: exc_bd=1, exc_pc=32'h8000_0010 -> EPC=32'h8000_000C, Cause.BD=1. A second exception with exc_pc=32'h8000_0020 -> EPC unchanged, ExcCode updated.
- Simultaneous commit: exc_valid, eret and mtc0_we to EPC in the same cycle -> EXL=1, and EPC is from the exception, not from mtc0_wdata.
- Interrupt enable: MTC0 Status=32'h0000_0401, then hw_int=6'b000001 -> int_req=1 on the cycle after sampling; eret or EXL=1 masks it.
- Write masking: MTC0 Cause=32'hFFFF_FFFF -> reads 32'h0000_0300 (with hw_int=0, TI=0). MTC0 BadVAddr -> unchanged.
- CP0_TIMER_EN defined: MTC0 Compare=5, Count=0 -> TI=1 about 10 cycles later and int_req follows if IM7 is set. MTC0 Compare clears TI. MTC0 Count=32'hFFFF_FFFF -> wraps to 0.

Source files
------------

// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - MIPS-style CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_valid,
   input  logic [4:0]  exc_code,
   input  logic        exc_bd,
   input  logic [31:0] exc_pc,
   input  logic        badaddr_we,
   input  logic [31:0] exc_badaddr,
   input  logic        eret,
   input  logic        mtc0_we,
   input  logic [4:0]  mtc0_addr,
   input  logic [31:0] mtc0_wdata,
   input  logic [4:0]  mfc0_addr,
   input  logic [5:0]  hw_int,
   output logic [31:0] mfc0_rdata,
   output logic [31:0] epc_out,
   output logic        status_exl,
   output logic        int_req
);

   localparam logic [4:0] ADDR_BADVADDR = 5'd8;
   localparam logic [4:0] ADDR_COUNT    = 5'd9;
   localparam logic [4:0] ADDR_COMPARE  = 5'd11;
   localparam logic [4:0] ADDR_STATUS   = 5'd12;
   localparam logic [4:0] ADDR_CAUSE    = 5'd13;
   localparam logic [4:0] ADDR_EPC      = 5'd14;

   logic [7:0]  im_q, im_d;
   logic        exl_q, exl_d, ie_q, ie_d;
   logic        bd_q, bd_d, ti_q, ti_d;
   logic [5:0]  ip_hw_q, ip_hw_d;
   logic [1:0]  ip_sw_q, ip_sw_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
   logic [31:0] count_rd, compare_rd, status_rd, cause_rd;
   logic        mtc0_commit;

   // A lower-priority commit in the same cycle as an exception or ERET is dropped.
   assign mtc0_commit = mtc0_we & ~exc_valid & ~eret;

   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ip_sw_d    = ip_sw_q;
      exccode_d  = exccode_q;
      epc_d      = epc_q;
      badvaddr_d = badvaddr_q;
      ip_hw_d    = {hw_int[5] | ti_q, hw_int[4:0]};
      if (exc_valid) begin
         exl_d     = 1'b1;
         exccode_d = exc_code;
         if (!exl_q) begin
            bd_d  = exc_bd;
            epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
         end
         if (badaddr_we) badvaddr_d = exc_badaddr;
      end else if (eret) begin
         exl_d = 1'b0;
      end else if (mtc0_we) begin
         case (mtc0_addr)
            ADDR_STATUS: begin
               im_d  = mtc0_wdata[15:8];
               exl_d = mtc0_wdata[1];
               ie_d  = mtc0_wdata[0];
            end
            ADDR_CAUSE: ip_sw_d = mtc0_wdata[9:8];
            ADDR_EPC:   epc_d   = mtc0_wdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ti_q       <= 1'b0;
         ip_hw_q    <= '0;
         ip_sw_q    <= '0;
         exccode_q  <= '0;
         epc_q      <= '0;
         badvaddr_q <= '0;
      end else begin
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ti_q       <= ti_d;
         ip_hw_q    <= ip_hw_d;
         ip_sw_q    <= ip_sw_d;
         exccode_q  <= exccode_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
      end
   end

`ifdef CP0_TIMER_EN
   logic [31:0] count_q, count_d, compare_q, compare_d;
   logic        tick_q, tick_d;

   // Count advances on every other clock; a software write restarts the phase.
   always_comb begin
      count_d   = count_q;
      compare_d = compare_q;
      tick_d    = ~tick_q;
      ti_d      = ti_q;
      if (mtc0_commit && mtc0_addr == ADDR_COUNT) begin
         count_d = mtc0_wdata;
         tick_d  = 1'b0;
      end else if (tick_q) begin
         count_d = count_q + 32'd1;
      end
      if (mtc0_commit && mtc0_addr == ADDR_COMPARE) begin
         compare_d = mtc0_wdata;
         ti_d      = 1'b0;
      end else if (count_q == compare_q && compare_q != 32'd0) begin
         ti_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         compare_q <= '0;
         tick_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         tick_q    <= tick_d;
      end
   end

   assign count_rd   = count_q;
   assign compare_rd = compare_q;
`else
   assign ti_d       = 1'b0;
   assign count_rd   = '0;
   assign compare_rd = '0;
`endif

   assign status_rd = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
   assign cause_rd  = {bd_q, ti_q, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};

   always_comb begin
      case (mfc0_addr)
         ADDR_BADVADDR: mfc0_rdata = badvaddr_q;
         ADDR_COUNT:    mfc0_rdata = count_rd;
         ADDR_COMPARE:  mfc0_rdata = compare_rd;
         ADDR_STATUS:   mfc0_rdata = status_rd;
         ADDR_CAUSE:    mfc0_rdata = cause_rd;
         ADDR_EPC:      mfc0_rdata = epc_q;
         default:       mfc0_rdata = 32'h0;
      endcase
   end

   assign epc_out    = epc_q;
   assign status_exl = exl_q;
   assign int_req    = ie_q & ~exl_q & |({ip_hw_q, ip_sw_q} & im_q);

endmodule

// File: tb/tb_cp0_regfile.sv
// tb/tb_cp0_regfile.sv - directed, table-driven bench for cp0_regfile.
module tb_cp0_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        exc_valid, exc_bd, badaddr_we, eret, mtc0_we;
   logic [4:0]  exc_code, mtc0_addr, mfc0_addr;
   logic [31:0] exc_pc, exc_badaddr, mtc0_wdata;
   logic [5:0]  hw_int;
   logic [31:0] mfc0_rdata, epc_out;
   logic        status_exl, int_req;

   int checks = 0;
   int errors = 0;

`ifdef CP0_TIMER_EN
   localparam bit TIMER = 1'b1;
`else
   localparam bit TIMER = 1'b0;
`endif

   cp0_regfile dut (
      .clk(clk), .rst(rst),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_bd(exc_bd), .exc_pc(exc_pc),
      .badaddr_we(badaddr_we), .exc_badaddr(exc_badaddr),
      .eret(eret), .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
      .mfc0_addr(mfc0_addr), .hw_int(hw_int),
      .mfc0_rdata(mfc0_rdata), .epc_out(epc_out), .status_exl(status_exl), .int_req(int_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] v);
      mfc0_addr = a;
      #1;
      v = mfc0_rdata;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      mtc0_we = 1'b1; mtc0_addr = a; mtc0_wdata = d;
      step();
      mtc0_we = 1'b0;
   endtask

   task automatic exc(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                      input logic bwe, input logic [31:0] baddr);
      exc_valid = 1'b1; exc_code = code; exc_bd = bd; exc_pc = pc;
      badaddr_we = bwe; exc_badaddr = baddr;
      step();
      exc_valid = 1'b0; badaddr_we = 1'b0;
   endtask

   task automatic do_eret();
      eret = 1'b1;
      step();
      eret = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      logic [31:0] v;
      int n;
      rst = 1'b1; exc_valid = 0; exc_code = 0; exc_bd = 0; exc_pc = 0;
      badaddr_we = 0; exc_badaddr = 0; eret = 0; mtc0_we = 0; mtc0_addr = 0;
      mtc0_wdata = 0; mfc0_addr = 0; hw_int = 0;

      vecs[0] = '{"status_all_ones", 5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0040_FF03};
      vecs[1] = '{"status_zero",     5'd12, 32'h0000_0000, 5'd12, 32'h0040_0000};
      vecs[2] = '{"cause_mask",      5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300};
      vecs[3] = '{"cause_clear",     5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000};
      vecs[4] = '{"epc_write",       5'd14, 32'h1234_5678, 5'd14, 32'h1234_5678};
      vecs[5] = '{"badvaddr_ro",     5'd8,  32'hDEAD_BEEF, 5'd8,  32'h0000_0000};
      vecs[6] = '{"unimpl_5",        5'd5,  32'hFFFF_FFFF, 5'd5,  32'h0000_0000};
      vecs[7] = '{"unimpl_31",       5'd14, 32'hA5A5_A5A5, 5'd31, 32'h0000_0000};
      vecs[8] = '{"compare_write",   5'd11, 32'h0000_1234, 5'd11, TIMER ? 32'h0000_1234 : 32'h0};
      vecs[9] = '{"count_write",     5'd9,  32'h0000_0077, 5'd9,  TIMER ? 32'h0000_0077 : 32'h0};

      // Values held while reset is asserted
      repeat (2) step();
      rd(5'd12, v); check("rst_status", v, 32'h0040_0000);
      rd(5'd13, v); check("rst_cause", v, 32'h0);
      rd(5'd14, v); check("rst_epc", v, 32'h0);
      rd(5'd8, v);  check("rst_badvaddr", v, 32'h0);
      check("rst_outs", {int_req, status_exl, epc_out}, 34'h0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 10; i++) begin
         mtc0(vecs[i].wa, vecs[i].wd);
         rd(vecs[i].ra, v);
         check(vecs[i].name, v, vecs[i].exp);
      end

      // Exception outside a delay slot
      do_reset();
      exc(5'd4, 1'b0, 32'hBFC0_0100, 1'b1, 32'h0000_0003);
      check("exc_epc", epc_out, 32'hBFC0_0100);
      rd(5'd13, v); check("exc_cause", v, 32'h0000_0010);
      rd(5'd8, v);  check("exc_badvaddr", v, 32'h0000_0003);
      check("exc_exl", status_exl, 1'b1);
      do_eret();
      check("eret_exl", status_exl, 1'b0);
      check("eret_epc", epc_out, 32'hBFC0_0100);

      // Delay-slot exception, then nested exception with EXL set
      exc(5'd5, 1'b1, 32'h8000_0010, 1'b0, 32'hFFFF_FFFF);
      check("bd_epc", epc_out, 32'h8000_000C);
      rd(5'd13, v); check("bd_cause", v, 32'h8000_0014);
      exc(5'd6, 1'b0, 32'h8000_0020, 1'b0, 32'h0);
      check("nested_epc", epc_out, 32'h8000_000C);
      rd(5'd13, v); check("nested_cause", v, 32'h8000_0018);
      rd(5'd8, v);  check("nested_badvaddr", v, 32'h0000_0003);

      // Exception, ERET and MTC0 committed together
      do_reset();
      eret = 1'b1; mtc0_we = 1'b1; mtc0_addr = 5'd14; mtc0_wdata = 32'hFFFF_0000;
      exc(5'd8, 1'b0, 32'h0000_1000, 1'b0, 32'h0);
      eret = 1'b0; mtc0_we = 1'b0;
      check("simul_exl", status_exl, 1'b1);
      check("simul_epc", epc_out, 32'h0000_1000);

      // Interrupt enable and masking
      do_eret();
      mtc0(5'd12, 32'h0000_0401);
      rd(5'd12, v); check("ie_status", v, 32'h0040_0401);
      hw_int = 6'b000001;
      #1; check("int_before_sample", int_req, 1'b0);
      step();
      check("int_req_set", int_req, 1'b1);
      rd(5'd13, v); check("int_cause_ip2", v, 32'h0000_0420);
      exc(5'd0, 1'b0, 32'h0000_2000, 1'b0, 32'h0);
      check("int_masked_exl", int_req, 1'b0);
      do_eret();
      check("int_after_eret", int_req, 1'b1);
      mtc0(5'd12, 32'h0000_0400);
      check("int_masked_ie", int_req, 1'b0);
      hw_int = 6'b0;

      // Reset asserted alongside a commit discards it
      rst = 1'b1;
      exc(5'd3, 1'b0, 32'h0000_4000, 1'b1, 32'h0000_0044);
      rst = 1'b0;
      check("rst_commit_epc", epc_out, 32'h0);
      check("rst_commit_exl", status_exl, 1'b0);
      rd(5'd8, v); check("rst_commit_badvaddr", v, 32'h0);
      step();

`ifdef CP0_TIMER_EN
      mtc0(5'd12, 32'h0000_8001);
      mtc0(5'd9, 32'd100);
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      n = 0;
      mfc0_addr = 5'd13;
      while (n < 40) begin
         step();
         n++;
         if (mfc0_rdata[30]) break;
      end
      check("ti_latency", n, 11);
      check("ti_no_int_yet", int_req, 1'b0);
      step();
      check("ti_int_req", int_req, 1'b1);
      mtc0(5'd11, 32'd0);
      rd(5'd13, v); check("ti_cleared", v[30], 1'b0);
      mtc0(5'd9, 32'hFFFF_FFFF);
      rd(5'd9, v); check("count_max", v, 32'hFFFF_FFFF);
      step(); step();
      rd(5'd9, v); check("count_wrap", v, 32'h0);
`else
      mtc0(5'd12, 32'h0000_8001);
      mtc0(5'd9, 32'h0000_0055);
      rd(5'd9, v); check("count_disabled", v, 32'h0);
      mtc0(5'd11, 32'h0000_0001);
      repeat (20) step();
      rd(5'd13, v); check("ti_disabled", v[30], 1'b0);
      check("int_disabled", int_req, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
